l_class_oc_fifon: RTL and testbench

L_CLASS_OC_FIFON -- requirements
Module: l_class_OC_FifoN

---
 rtl/l_class_oc_fifon.sv | 115 +++++++++++
 tb/tb_l_class_oc_fifon.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/l_class_oc_fifon.sv
// ---------------------------------------------------------------------------
// l_class_oc_fifon
//   Circular-buffer FIFO with enq/deq/first/clear method ports in the
//   RDY/ENA handshake style. Every RDY is decoded from registered state only,
//   so no ENA input has a combinational path to any RDY.
//
// Parameters
//   WIDTH      data width in bits (>= 1)
//   DEPTH      number of entries (power of 2, >= 2)
//
// Ports
//   CLK        single clock; all state changes on its rising edge
//   nRST       synchronous active-low reset (pointers, count, error)
//   enq__RDY   high when not full
//   enq__ENA   enqueue enq_v this cycle
//   enq_v      data to enqueue
//   deq__RDY   high when not empty
//   deq__ENA   discard the head entry this cycle
//   first__RDY high when first holds a valid entry
//   first      head entry (combinational read of storage)
//   clear__RDY always high
//   clear__ENA empty the FIFO and drop the error flag on the next edge
//   count      occupied entries, 0..DEPTH
//   error      sticky flag: an ENA was raised while its RDY was low
// ---------------------------------------------------------------------------
module l_class_oc_fifon #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             nRST,
    output logic             enq__RDY,
    input  logic             enq__ENA,
    input  logic [WIDTH-1:0] enq_v,
    output logic             deq__RDY,
    input  logic             deq__ENA,
    output logic             first__RDY,
    output logic [WIDTH-1:0] first,
    output logic             clear__RDY,
    input  logic             clear__ENA,
    output logic [CW-1:0]    count,
    output logic             error
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_error;

    logic w_enq_rdy;
    logic w_deq_rdy;
    logic w_enq_fire;
    logic w_deq_fire;
    logic w_violation;
    logic w_mem_wr;

    assign w_enq_rdy   = (r_count != CW'(DEPTH));
    assign w_deq_rdy   = (r_count != '0);
    assign w_enq_fire  = enq__ENA & w_enq_rdy;
    assign w_deq_fire  = deq__ENA & w_deq_rdy;
    assign w_violation = (enq__ENA & ~w_enq_rdy) | (deq__ENA & ~w_deq_rdy);

    // A write that coincides with reset or clear is dropped along with the
    // pointer update, so storage only ever changes for an enq that counts.
    assign w_mem_wr    = w_enq_fire & nRST & ~clear__ENA;

    always_ff @(posedge CLK) begin
        if (w_mem_wr) begin
            r_mem[r_wptr] <= enq_v;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_error <= 1'b0;
        end else if (clear__ENA) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_error <= 1'b0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so increment wraps
            // DEPTH-1 -> 0 on its own.
            if (w_enq_fire) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_deq_fire) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_enq_fire, w_deq_fire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_violation) begin
                r_error <= 1'b1;
            end
        end
    end

    assign enq__RDY   = w_enq_rdy;
    assign deq__RDY   = w_deq_rdy;
    assign first__RDY = w_deq_rdy;
    assign first      = r_mem[r_rptr];
    assign clear__RDY = 1'b1;
    assign count      = r_count;
    assign error      = r_error;

endmodule

// File: tb/tb_l_class_oc_fifon.sv
// ---------------------------------------------------------------------------
// tb_l_class_oc_fifon
//   Directed bench for l_class_oc_fifon at WIDTH=32, DEPTH=4. Inputs change
//   1 time unit after a rising edge and outputs are sampled at the same point,
//   so every check sees the state produced by the edge just taken.
// ---------------------------------------------------------------------------
module tb_l_class_oc_fifon;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic             CLK;
    logic             nRST;
    logic             enq__RDY;
    logic             enq__ENA;
    logic [WIDTH-1:0] enq_v;
    logic             deq__RDY;
    logic             deq__ENA;
    logic             first__RDY;
    logic [WIDTH-1:0] first;
    logic             clear__RDY;
    logic             clear__ENA;
    logic [CW-1:0]    count;
    logic             error;

    int checks_reg;
    int errors_reg;

    l_class_oc_fifon #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .enq__RDY   (enq__RDY),
        .enq__ENA   (enq__ENA),
        .enq_v      (enq_v),
        .deq__RDY   (deq__RDY),
        .deq__ENA   (deq__ENA),
        .first__RDY (first__RDY),
        .first      (first),
        .clear__RDY (clear__RDY),
        .clear__ENA (clear__ENA),
        .count      (count),
        .error      (error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_reg++;
        if (obs !== exp) begin
            errors_reg++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        enq__ENA   = 1'b0;
        deq__ENA   = 1'b0;
        clear__ENA = 1'b0;
    endtask

    task automatic do_enq(input logic [31:0] v);
        enq__ENA = 1'b1;
        enq_v    = v;
        step();
        enq__ENA = 1'b0;
    endtask

    task automatic do_deq();
        deq__ENA = 1'b1;
        step();
        deq__ENA = 1'b0;
    endtask

    initial begin
        checks_reg = 0;
        errors_reg = 0;
        nRST  = 1'b0;
        enq_v = '0;
        idle();
        step();
        step();
        nRST = 1'b1;

        // Reset state
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_enq_rdy", 32'(enq__RDY), 32'd1);
        check_val("rst_deq_rdy", 32'(deq__RDY), 32'd0);
        check_val("rst_first_rdy", 32'(first__RDY), 32'd0);
        check_val("rst_error", 32'(error), 32'd0);
        check_val("rst_clear_rdy", 32'(clear__RDY), 32'd1);

        // Fill: A, B, C, D
        for (int i = 0; i < 4; i++) begin
            do_enq(32'hA + 32'(i));
            check_val($sformatf("fill_count%0d", i), 32'(count), 32'(i + 1));
            check_val($sformatf("fill_first%0d", i), first, 32'hA);
        end
        check_val("full_enq_rdy", 32'(enq__RDY), 32'd0);
        check_val("full_deq_rdy", 32'(deq__RDY), 32'd1);

        // Drain: heads B, C, D then empty
        for (int i = 0; i < 4; i++) begin
            do_deq();
            check_val($sformatf("drain_count%0d", i), 32'(count), 32'(3 - i));
            if (i < 3) begin
                check_val($sformatf("drain_first%0d", i), first, 32'hB + 32'(i));
            end
        end
        check_val("empty_deq_rdy", 32'(deq__RDY), 32'd0);
        check_val("empty_first_rdy", 32'(first__RDY), 32'd0);
        check_val("empty_enq_rdy", 32'(enq__RDY), 32'd1);

        // Streaming at count 2: values 1..12 enqueued, head after cycle i is i+2
        do_enq(32'd1);
        do_enq(32'd2);
        for (int i = 0; i < 10; i++) begin
            enq__ENA = 1'b1;
            deq__ENA = 1'b1;
            enq_v    = 32'(i + 3);
            step();
            check_val($sformatf("stream_count%0d", i), 32'(count), 32'd2);
            check_val($sformatf("stream_first%0d", i), first, 32'(i + 2));
        end
        idle();
        do_deq();
        check_val("stream_tail_first", first, 32'd12);
        do_deq();
        check_val("stream_tail_count", 32'(count), 32'd0);
        check_val("stream_error", 32'(error), 32'd0);

        // Violation: deq while empty
        do_deq();
        check_val("viol_deq_count", 32'(count), 32'd0);
        check_val("viol_deq_error", 32'(error), 32'd1);
        step();
        check_val("viol_deq_sticky", 32'(error), 32'd1);
        clear__ENA = 1'b1;
        step();
        clear__ENA = 1'b0;
        check_val("viol_clear_error", 32'(error), 32'd0);

        // Violation: enq while full leaves contents intact
        for (int i = 0; i < 4; i++) begin
            do_enq(32'h10 + 32'(i));
        end
        do_enq(32'h99);
        check_val("viol_enq_count", 32'(count), 32'd4);
        check_val("viol_enq_error", 32'(error), 32'd1);
        check_val("viol_enq_first", first, 32'h10);
        do_deq();
        do_deq();
        do_deq();
        check_val("viol_enq_last", first, 32'h13);

        // Clear + enq at count 3
        clear__ENA = 1'b1;
        step();
        clear__ENA = 1'b0;
        check_val("clr_count", 32'(count), 32'd0);
        check_val("clr_error", 32'(error), 32'd0);
        do_enq(32'h20);
        do_enq(32'h21);
        do_enq(32'h22);
        check_val("pre_clr_count", 32'(count), 32'd3);
        clear__ENA = 1'b1;
        enq__ENA   = 1'b1;
        enq_v      = 32'h23;
        step();
        idle();
        check_val("clr_enq_count", 32'(count), 32'd0);
        check_val("clr_enq_first_rdy", 32'(first__RDY), 32'd0);
        check_val("clr_enq_enq_rdy", 32'(enq__RDY), 32'd1);

        // Reset at count 3 while enq/deq are active
        do_enq(32'h30);
        do_enq(32'h31);
        do_enq(32'h32);
        check_val("pre_rst_count", 32'(count), 32'd3);
        nRST     = 1'b0;
        enq__ENA = 1'b1;
        deq__ENA = 1'b1;
        enq_v    = 32'h33;
        step();
        nRST = 1'b1;
        idle();
        check_val("mid_rst_count", 32'(count), 32'd0);
        check_val("mid_rst_error", 32'(error), 32'd0);
        check_val("mid_rst_enq_rdy", 32'(enq__RDY), 32'd1);
        check_val("mid_rst_first_rdy", 32'(first__RDY), 32'd0);
        do_enq(32'h5);
        check_val("post_rst_first", first, 32'h5);
        check_val("post_rst_count", 32'(count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks_reg, errors_reg);
        $finish;
    end

endmodule
